program_flow_controller: RTL
============================

// Module: program_flow_controller
// PURPOSE
//  Multi-cycle sequencer for the instruction address generator. Steps each instruction
//  through FETCH/DECODE/EXEC/UPDATE and drives PC_select, PC_enable and INC_select.
//  Holds a small return-address stack (RAS) for call/return; the stack top feeds the RA input.
//  Sits between the instruction decoder/ALU handshakes and the address generator.
// PARAMETERS
//  ADDR_W     32  width of PC_temp and RA
//  RAS_DEPTH  4   return-address stack entries (power of 2, >=2)
// PORTS
//  Clock          in   1       single system clock; all state updates on posedge
//  Reset          in   1       synchronous, active-high; overrides all other inputs
//  Start          in   1       leave IDLE and begin fetching
//  IR_Valid       in   1       instruction memory returned the instruction (FETCH handshake)
//  Op_Class       in   3       0 ALU, 1 cond branch, 2 jump imm, 3 call, 4 return, 5 halt, 6-7 = ALU
//  Exec_Done      in   1       execute stage finished (EXEC handshake)
//  Branch_Taken   in   1       branch condition; sampled only on the EXEC cycle with Exec_Done=1
//  PC_temp        in   ADDR_W  current PC as registered by the address generator
//  PC_select      out  2       00 RA, 01 PC+inc, 10 branch/jump immediate
//  PC_enable      out  1       PC load strobe
//  INC_select     out  1       0 increment by 1, 1 increment by branch offset
//  RA             out  ADDR_W  RAS top entry; 0 when stack empty
//  Fetch_Req      out  1       request to instruction memory
//  Halted         out  1       halt instruction retired
//  RAS_Overflow   out  1       sticky: call with full stack
//  RAS_Underflow  out  1       sticky: return with empty stack
//  State          out  3       IDLE 0, FETCH 1, DECODE 2, EXEC 3, UPDATE 4, HALT 5
// BEHAVIOUR
//  - Reset: State=IDLE; RAS emptied (count=0); PC_enable=0, INC_select=0, PC_select=01,
//    Fetch_Req=0, Halted=0, both sticky flags=0, RA=0. Reset mid-instruction aborts it; no PC load.
//  - IDLE: Start=1 -> FETCH, else stay.
//  - FETCH: Fetch_Req=1; stay until IR_Valid=1, then latch Op_Class -> DECODE.
//  - DECODE: one cycle. Latched class 5 -> HALT; otherwise -> EXEC.
//  - EXEC: stay until Exec_Done=1; latch Branch_Taken on that cycle -> UPDATE.
//  - UPDATE: one cycle, PC_enable=1, then -> FETCH. Selects by latched class:
//     ALU: PC_select=01, INC_select=0.
//     branch: PC_select=01, INC_select=Branch_Taken (latched).
//     jump: PC_select=10.
//     call: PC_select=10; push PC_temp+1 (mod 2^ADDR_W). If full: no push,
//       RAS_Overflow<=1, jump still taken.
//     return, not empty: PC_select=00, RA=top; pop at end of cycle.
//     return, empty: PC_select=01, INC_select=0 (fall through), RAS_Underflow<=1.
//  - PC_select/INC_select/PC_enable are Moore outputs of State + latched class/flag.
//    Outside UPDATE: PC_enable=0, PC_select=01, INC_select=0.
//  - HALT: Halted=1; Start ignored; leave only via Reset.
//  - Latency: minimum 4 cycles per instruction (FETCH, DECODE, EXEC, UPDATE) with
//    IR_Valid and Exec_Done high on first sample. Each wait cycle adds 1.
//  - RAS is a LIFO with count 0..RAS_DEPTH; push and pop never occur in the same cycle.
//  - RA updates the cycle after a push or pop.
// TESTING
//  1 Reset, Start, 3 ALU ops with IR_Valid/Exec_Done held high -> PC_enable pulses every
//    4th cycle, PC_select=01, INC_select=0.
//  2 Branch, Branch_Taken=1 then 0 -> UPDATE INC_select=1, then 0.
//    Branch_Taken toggling before Exec_Done is ignored.
//  3 Call at PC_temp=0x10, then return -> RA=0x11 after push; return UPDATE PC_select=00;
//    RA=0 after pop.
//  4 Five calls with RAS_DEPTH=4 -> 5th sets RAS_Overflow, count stays 4.
//    Then five returns -> 5th sets RAS_Underflow and uses PC_select=01.
//  5 IR_Valid delayed 3 cycles, Exec_Done delayed 2 -> instruction takes 9 cycles;
//    Fetch_Req high for all 4 FETCH cycles.
//  6 Halt op -> State=5, Halted=1, Start ignored. Reset asserted during EXEC of a call ->
//    no push, no PC_enable, State=IDLE next cycle.

Source files
------------

// File: rtl/program_flow_controller_if.sv
// Handshake/control bundle between the program flow controller, the instruction
// decoder/ALU handshakes and the instruction address generator.
//   slave  : controller view (handshake inputs in, PC controls and status out)
//   master : environment view (drives handshakes, observes PC controls)
interface program_flow_controller_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic              Start;
   logic              IR_Valid;
   logic [2:0]        Op_Class;
   logic              Exec_Done;
   logic              Branch_Taken;
   logic [ADDR_W-1:0] PC_temp;
   logic [1:0]        PC_select;
   logic              PC_enable;
   logic              INC_select;
   logic [ADDR_W-1:0] RA;
   logic              Fetch_Req;
   logic              Halted;
   logic              RAS_Overflow;
   logic              RAS_Underflow;
   logic [2:0]        State;

   modport master (
      output Start, IR_Valid, Op_Class, Exec_Done, Branch_Taken, PC_temp,
      input  PC_select, PC_enable, INC_select, RA, Fetch_Req, Halted,
             RAS_Overflow, RAS_Underflow, State
   );

   modport slave (
      input  Start, IR_Valid, Op_Class, Exec_Done, Branch_Taken, PC_temp,
      output PC_select, PC_enable, INC_select, RA, Fetch_Req, Halted,
             RAS_Overflow, RAS_Underflow, State
   );
endinterface

// File: rtl/program_flow_controller.sv
// Multi-cycle sequencer for the instruction address generator. Each instruction walks
// FETCH -> DECODE -> EXEC -> UPDATE; UPDATE issues the PC load with the select lines
// chosen by the latched operation class. A small return-address stack serves call/return.
// Ports:
//   Clock   : system clock, all state updates on posedge
//   Reset   : synchronous, active-high, overrides everything
//   ctrl_io : handshake inputs (Start, IR_Valid, Op_Class, Exec_Done, Branch_Taken, PC_temp)
//             and outputs (PC_select, PC_enable, INC_select, RA, Fetch_Req, Halted,
//             RAS_Overflow, RAS_Underflow, State)
module program_flow_controller #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input logic                      Clock,
   input logic                      Reset,
   program_flow_controller_if.slave ctrl_io
);

   localparam int unsigned PtrW = $clog2(RAS_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [2:0] ClsBranch = 3'd1;
   localparam logic [2:0] ClsJump   = 3'd2;
   localparam logic [2:0] ClsCall   = 3'd3;
   localparam logic [2:0] ClsRet    = 3'd4;
   localparam logic [2:0] ClsHalt   = 3'd5;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StUpdate = 3'd4,
      StHalt   = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        class_q, class_d;
   logic              taken_q, taken_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
   logic [ADDR_W-1:0] stack_d [RAS_DEPTH];
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [1:0]        pc_sel_q, pc_sel_d;
   logic              pc_en_q, pc_en_d;
   logic              inc_sel_q, inc_sel_d;
   logic              fetch_q, fetch_d;
   logic              halted_q, halted_d;
   logic [CntW-1:0]   top_cnt;
   logic [ADDR_W-1:0] ra;

   always_comb begin
      state_d = state_q;
      class_d = class_q;
      taken_d = taken_q;
      count_d = count_q;
      stack_d = stack_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;

      case (state_q)
         StIdle:   if (ctrl_io.Start) state_d = StFetch;
         StFetch: begin
            if (ctrl_io.IR_Valid) begin
               class_d = ctrl_io.Op_Class;
               state_d = StDecode;
            end
         end
         StDecode: state_d = (class_q == ClsHalt) ? StHalt : StExec;
         StExec: begin
            if (ctrl_io.Exec_Done) begin
               taken_d = ctrl_io.Branch_Taken;
               state_d = StUpdate;
            end
         end
         StUpdate: begin
            state_d = StFetch;
            if (class_q == ClsCall) begin
               if (count_q == CntW'(RAS_DEPTH)) begin
                  ovf_d = 1'b1;
               end else begin
                  stack_d[count_q[PtrW-1:0]] = ctrl_io.PC_temp + ADDR_W'(1);
                  count_d = count_q + CntW'(1);
               end
            end else if (class_q == ClsRet) begin
               if (count_q == '0) unf_d = 1'b1;
               else               count_d = count_q - CntW'(1);
            end
         end
         StHalt:   state_d = StHalt;
         default:  state_d = StIdle;
      endcase

      // Outputs are registered, so decode them from the state being entered.
      // class_q/count_q are stable between EXEC and UPDATE, taken_d is the value latched now.
      pc_en_d   = (state_d == StUpdate);
      pc_sel_d  = 2'b01;
      inc_sel_d = 1'b0;
      fetch_d   = (state_d == StFetch);
      halted_d  = (state_d == StHalt);
      if (state_d == StUpdate) begin
         case (class_q)
            ClsBranch:        inc_sel_d = taken_d;
            ClsJump, ClsCall: pc_sel_d  = 2'b10;
            ClsRet:           if (count_q != '0) pc_sel_d = 2'b00;
            default:          pc_sel_d  = 2'b01;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= StIdle;
         class_q   <= '0;
         taken_q   <= 1'b0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         pc_sel_q  <= 2'b01;
         pc_en_q   <= 1'b0;
         inc_sel_q <= 1'b0;
         fetch_q   <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         taken_q   <= taken_d;
         count_q   <= count_d;
         stack_q   <= stack_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         pc_sel_q  <= pc_sel_d;
         pc_en_q   <= pc_en_d;
         inc_sel_q <= inc_sel_d;
         fetch_q   <= fetch_d;
         halted_q  <= halted_d;
      end
   end

   // Stack entries are not reset; RA is gated by the count so stale entries never show.
   always_comb begin
      top_cnt = count_q - CntW'(1);
      ra      = '0;
      if (count_q != '0) ra = stack_q[top_cnt[PtrW-1:0]];
   end

   assign ctrl_io.PC_select     = pc_sel_q;
   assign ctrl_io.PC_enable     = pc_en_q;
   assign ctrl_io.INC_select    = inc_sel_q;
   assign ctrl_io.RA            = ra;
   assign ctrl_io.Fetch_Req     = fetch_q;
   assign ctrl_io.Halted        = halted_q;
   assign ctrl_io.RAS_Overflow  = ovf_q;
   assign ctrl_io.RAS_Underflow = unf_q;
   assign ctrl_io.State         = state_q;

endmodule
